eink_panel_receiver: RTL

EINK_PANEL_RECEIVER -- requirements
Module: eink_panel_receiver

---
 rtl/eink_panel_receiver.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/eink_panel_receiver.sv
// E-ink panel SPI receiver: mode-0 SPI slave oversampled by the system clock.
// Decodes command/data bytes, tracks the data index and models the panel busy period after a refresh.
module eink_panel_receiver #(
  parameter int unsigned BUSY_CYCLES = 1000,
  parameter logic [7:0]  REFRESH_CMD = 8'h20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spi_sclk,
  input  logic        spi_mosi,
  input  logic        spi_cs_n,
  input  logic        spi_dc,
  output logic        busy,
  output logic        cmd_valid,
  output logic [7:0]  cmd_byte,
  output logic        data_valid,
  output logic [7:0]  data_byte,
  output logic [15:0] data_index,
  output logic        frame_err,
  output logic        overrun
);

  localparam int CNT_W = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;
  localparam logic [CNT_W-1:0] BUSY_LOAD = CNT_W'(BUSY_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_BUSY
  } state_t;

  state_t state_q, state_d;

  logic sclk_meta_q, sclk_meta_d, sclk_sync_q, sclk_sync_d, sclk_prev_q, sclk_prev_d;
  logic mosi_meta_q, mosi_meta_d, mosi_sync_q, mosi_sync_d;
  logic cs_meta_q, cs_meta_d, cs_sync_q, cs_sync_d;
  logic dc_meta_q, dc_meta_d, dc_sync_q, dc_sync_d;

  logic [7:0]       shift_q, shift_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic             byte_done_q, byte_done_d;
  logic [7:0]       pend_byte_q, pend_byte_d;
  logic             pend_dc_q, pend_dc_d;
  logic             start_busy_q, start_busy_d;
  logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;
  logic [15:0]      data_count_q, data_count_d;

  logic        busy_q, busy_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic [7:0]  cmd_byte_q, cmd_byte_d;
  logic        data_valid_q, data_valid_d;
  logic [7:0]  data_byte_q, data_byte_d;
  logic [15:0] data_index_q, data_index_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;

  logic sclk_rise;
  logic [7:0] shifted;

  assign sclk_rise = sclk_sync_q & ~sclk_prev_q;
  assign shifted   = {shift_q[6:0], mosi_sync_q};

  // Next-state logic: synchronizers, bit shifting, FSM, byte decode and busy timer.
  always_comb begin
    sclk_meta_d  = spi_sclk;
    sclk_sync_d  = sclk_meta_q;
    sclk_prev_d  = sclk_sync_q;
    mosi_meta_d  = spi_mosi;
    mosi_sync_d  = mosi_meta_q;
    cs_meta_d    = spi_cs_n;
    cs_sync_d    = cs_meta_q;
    dc_meta_d    = spi_dc;
    dc_sync_d    = dc_meta_q;

    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    byte_done_d  = 1'b0;
    pend_byte_d  = pend_byte_q;
    pend_dc_d    = pend_dc_q;
    start_busy_d = 1'b0;
    busy_cnt_d   = busy_cnt_q;
    data_count_d = data_count_q;
    busy_d       = busy_q;
    cmd_valid_d  = 1'b0;
    cmd_byte_d   = cmd_byte_q;
    data_valid_d = 1'b0;
    data_byte_d  = data_byte_q;
    data_index_d = data_index_q;
    frame_err_d  = 1'b0;
    overrun_d    = overrun_q;

    case (state_q)
      ST_IDLE: begin
        if (!cs_sync_q && !busy_q) begin
          state_d   = ST_SHIFT;
          bit_cnt_d = 3'd0;
        end
      end
      ST_SHIFT: begin
        if (cs_sync_q) begin
          state_d     = ST_IDLE;
          frame_err_d = (bit_cnt_q != 3'd0);
          bit_cnt_d   = 3'd0;
        end else if (sclk_rise) begin
          shift_d   = shifted;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            byte_done_d = 1'b1;
            pend_byte_d = shifted;
            pend_dc_d   = dc_sync_q;
          end
        end
      end
      ST_BUSY: begin
        if (cs_sync_q) begin
          bit_cnt_d = 3'd0;
        end else if (sclk_rise) begin
          shift_d   = shifted;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            byte_done_d = 1'b1;
            pend_byte_d = shifted;
            pend_dc_d   = dc_sync_q;
          end
        end
        if (busy_cnt_q == '0) begin
          busy_d    = 1'b0;
          bit_cnt_d = 3'd0;
          state_d   = cs_sync_q ? ST_IDLE : ST_SHIFT;
        end else begin
          busy_cnt_d = busy_cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A completed byte is published one cycle after assembly, or dropped as an overrun while busy.
    if (byte_done_q) begin
      if (busy_q) begin
        overrun_d = 1'b1;
      end else if (pend_dc_q) begin
        data_byte_d  = pend_byte_q;
        data_valid_d = 1'b1;
        data_index_d = data_count_q;
        data_count_d = data_count_q + 16'd1;
      end else begin
        cmd_byte_d   = pend_byte_q;
        cmd_valid_d  = 1'b1;
        data_count_d = 16'd0;
        start_busy_d = (pend_byte_q == REFRESH_CMD);
      end
    end

    // Busy starts the cycle after the refresh command pulse, whatever the CS state.
    if (start_busy_q) begin
      state_d    = ST_BUSY;
      busy_d     = 1'b1;
      busy_cnt_d = BUSY_LOAD;
    end
  end

  // State register with asynchronous active-low reset; CS synchronizer resets to deselected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sclk_meta_q  <= 1'b0;
      sclk_sync_q  <= 1'b0;
      sclk_prev_q  <= 1'b0;
      mosi_meta_q  <= 1'b0;
      mosi_sync_q  <= 1'b0;
      cs_meta_q    <= 1'b1;
      cs_sync_q    <= 1'b1;
      dc_meta_q    <= 1'b0;
      dc_sync_q    <= 1'b0;
      shift_q      <= 8'h00;
      bit_cnt_q    <= 3'd0;
      byte_done_q  <= 1'b0;
      pend_byte_q  <= 8'h00;
      pend_dc_q    <= 1'b0;
      start_busy_q <= 1'b0;
      busy_cnt_q   <= '0;
      data_count_q <= 16'd0;
      busy_q       <= 1'b0;
      cmd_valid_q  <= 1'b0;
      cmd_byte_q   <= 8'h00;
      data_valid_q <= 1'b0;
      data_byte_q  <= 8'h00;
      data_index_q <= 16'd0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sclk_meta_q  <= sclk_meta_d;
      sclk_sync_q  <= sclk_sync_d;
      sclk_prev_q  <= sclk_prev_d;
      mosi_meta_q  <= mosi_meta_d;
      mosi_sync_q  <= mosi_sync_d;
      cs_meta_q    <= cs_meta_d;
      cs_sync_q    <= cs_sync_d;
      dc_meta_q    <= dc_meta_d;
      dc_sync_q    <= dc_sync_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_done_q  <= byte_done_d;
      pend_byte_q  <= pend_byte_d;
      pend_dc_q    <= pend_dc_d;
      start_busy_q <= start_busy_d;
      busy_cnt_q   <= busy_cnt_d;
      data_count_q <= data_count_d;
      busy_q       <= busy_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_byte_q   <= cmd_byte_d;
      data_valid_q <= data_valid_d;
      data_byte_q  <= data_byte_d;
      data_index_q <= data_index_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign busy       = busy_q;
  assign cmd_valid  = cmd_valid_q;
  assign cmd_byte   = cmd_byte_q;
  assign data_valid = data_valid_q;
  assign data_byte  = data_byte_q;
  assign data_index = data_index_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule
